// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access stage: funct3 codes,
// FSM state encoding, byte-lane masks and an access-size decoder.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsigned variants only exist for loads; any unknown code falls back to a word.
  function automatic size_e access_size(input logic is_load, input logic [2:0] f3);
    if (f3 == F3_B || (is_load && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (is_load && f3 == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it to 32 bits.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? readdata[31:16] : readdata[15:0];
    result   = readdata;
    case (func3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues a handshaked data-memory request and stalls
// until acknowledge. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] address_in,
  input  logic [31:0] write_data_in,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] d_mem_result_out,
  output logic        stall_out,
  output logic        misalign_out
);

  state_e      state;
  logic        req_load;
  logic [2:0]  req_func3;
  logic [1:0]  req_lane;
  logic [31:0] formatted;

  logic        op_valid;
  logic        op_load;
  size_e       op_size;
  logic [1:0]  op_lane;
  logic [3:0]  op_be;
  logic [31:0] op_wdata;
  logic        trap;

  // A simultaneous read+write is a load; without the trap, low address bits
  // are silently dropped down to natural alignment.
  always_comb begin
    op_valid = mem_read_in | mem_write_in;
    op_load  = mem_read_in;
    op_size  = access_size(op_load, func3_in);
    op_lane  = address_in[1:0];
    op_be    = LANE_W;
    op_wdata = write_data_in;
    trap     = 1'b0;
    case (op_size)
      SZ_B: begin
        op_be    = LANE_B << op_lane;
        op_wdata = {4{write_data_in[7:0]}};
      end
      SZ_H: begin
        op_lane  = {address_in[1], 1'b0};
        op_be    = LANE_H << op_lane;
        op_wdata = {2{write_data_in[15:0]}};
`ifdef MISALIGN_TRAP_EN
        trap     = address_in[0];
`endif
      end
      default: begin
        op_lane  = 2'b00;
`ifdef MISALIGN_TRAP_EN
        trap     = |address_in[1:0];
`endif
      end
    endcase
  end

  load_formatter u_load_formatter (
    .readdata (mem_readdata),
    .addr     (req_lane),
    .func3    (req_func3),
    .result   (formatted)
  );

  assign stall_out = (state == IDLE && op_valid) || state == BUSY;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      req_load         <= 1'b0;
      req_func3        <= 3'b000;
      req_lane         <= 2'b00;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_address      <= 32'b0;
      mem_writedata    <= 32'b0;
      mem_byteenable   <= 4'b0;
      d_mem_result_out <= 32'b0;
      misalign_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misalign_out <= 1'b0;
          if (op_valid) begin
            req_load       <= op_load;
            req_func3      <= func3_in;
            req_lane       <= op_lane;
            mem_address    <= {address_in[31:2], 2'b00};
            mem_writedata  <= op_wdata;
            mem_byteenable <= op_be;
            if (trap) begin
              misalign_out <= 1'b1;
              state        <= DONE;
            end else begin
              mem_read  <= op_load;
              mem_write <= !op_load;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!mem_busywait) begin
            if (req_load) d_mem_result_out <= formatted;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // The pipeline advances after this cycle, so never look at the op inputs here.
          misalign_out <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// reset/misalign sequences, and random traffic against a behavioural model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  func3_in;
  logic [31:0] address_in, write_data_in, mem_readdata;
  logic        mem_busywait;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_writedata, d_mem_result_out;
  logic [3:0]  mem_byteenable;
  logic        stall_out, misalign_out;

  logic [31:0] fmt_rdata, fmt_result;
  logic [1:0]  fmt_addr;
  logic [2:0]  fmt_f3;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = 32'b0;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          stalls;
    int          reqs;
    int          mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] result;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic        stable;
    logic        after_req;
  } obs_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] word;
    int          waits;
    logic [31:0] exp_result;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic        exp_rd;
  } vec_t;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .func3_in         (func3_in),
    .address_in       (address_in),
    .write_data_in    (write_data_in),
    .mem_readdata     (mem_readdata),
    .mem_busywait     (mem_busywait),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .d_mem_result_out (d_mem_result_out),
    .stall_out        (stall_out),
    .misalign_out     (misalign_out)
  );

  load_formatter u_fmt (
    .readdata (fmt_rdata),
    .addr     (fmt_addr),
    .func3    (fmt_f3),
    .result   (fmt_result)
  );

  // Reference model: access size in bytes, aligned lane, and arithmetic lane extraction.
  function automatic int model_size(input logic is_load, input logic [2:0] f3);
    if (f3 == 3'd0 || (is_load && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (is_load && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic int model_lane(input logic [31:0] addr, input int size);
    return (int'(addr[1:0]) / size) * size;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int lane,
                                             input int size, input logic [2:0] f3);
    logic [31:0] mask;
    logic [31:0] v;
    if (size == 4) return word;
    mask = (32'd1 << (8 * size)) - 32'd1;
    v    = (word >> (8 * lane)) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input int lane, input int size);
    logic [31:0] m;
    m = ((32'd1 << size) - 32'd1) << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int size);
    if (size == 1) return {24'b0, wd[7:0]} * 32'h0101_0101;
    if (size == 2) return {16'b0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one op, acts as memory with 'waits' busy cycles, and records what it saw.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] word, input int waits,
                               input string tag, output obs_t o);
    int remaining;
    bit done;
    o = '{default: 0};
    o.stable  = 1'b1;
    remaining = waits;
    done      = 1'b0;
    mem_read_in   = rd;
    mem_write_in  = wr;
    func3_in      = f3;
    address_in    = addr;
    write_data_in = wd;
    mem_readdata  = word;
    #1;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (mem_read || mem_write) begin
        if (o.reqs == 0) begin
          o.addr  = mem_address;
          o.wdata = mem_writedata;
          o.be    = mem_byteenable;
          o.rd    = mem_read;
          o.wr    = mem_write;
        end else if ({mem_address, mem_writedata, mem_byteenable, mem_read, mem_write} !==
                     {o.addr, o.wdata, o.be, o.rd, o.wr}) begin
          o.stable = 1'b0;
        end
        o.reqs++;
        mem_busywait = (remaining > 0);
        if (remaining > 0) remaining--;
      end else begin
        mem_busywait = 1'($urandom_range(0, 1));
      end
      if (misalign_out) o.mis++;
      if (!stall_out) begin
        o.result = d_mem_result_out;
        done     = 1'b1;
      end else begin
        o.stalls++;
        @(posedge clk);
        #2;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.timeout: got stall_out=1 after 64 cycles expected 0", tag);
    end
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    @(posedge clk);
    #1;
    o.after_req = mem_read | mem_write;
  endtask

  task automatic compareObs(input string tag, input obs_t o, input obs_t e, input bit chk_wd);
    checkOutput({tag, ".stalls"}, 32'(o.stalls), 32'(e.stalls));
    checkOutput({tag, ".reqs"}, 32'(o.reqs), 32'(e.reqs));
    checkOutput({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
    checkOutput({tag, ".result"}, o.result, e.result);
    checkOutput({tag, ".reissue"}, 32'(o.after_req), 32'(0));
    if (e.reqs > 0) begin
      checkOutput({tag, ".addr"}, o.addr, e.addr);
      checkOutput({tag, ".be"}, 32'(o.be), 32'(e.be));
      checkOutput({tag, ".rd"}, 32'(o.rd), 32'(e.rd));
      checkOutput({tag, ".wr"}, 32'(o.wr), 32'(e.wr));
      checkOutput({tag, ".stable"}, 32'(o.stable), 32'(1));
      if (chk_wd) checkOutput({tag, ".wdata"}, o.wdata, e.wdata);
    end
  endtask

  initial begin
    vec_t vecs[10];
    obs_t o, e;

    vecs[0] = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0,
                32'hFFFF_FF80, 4'b1000, 32'h0, 32'h100, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 3,
                32'hFFFF_FF80, 4'b1100, 32'hABCD_ABCD, 32'h200, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 3'd5, 32'h002, 32'h0, 32'h8001_0000, 0,
                32'h0000_8001, 4'b1100, 32'h0, 32'h000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 3'd2, 32'h004, 32'h0, 32'hDEAD_BEEF, 0,
                32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h004, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 3'd2, 32'h010, 32'h0, 32'h1234_5678, 1,
                32'h1234_5678, 4'b1111, 32'h0, 32'h010, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 3'd0, 32'h011, 32'h0000_00A5, 32'h0, 2,
                32'h1234_5678, 4'b0010, 32'hA5A5_A5A5, 32'h010, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 3'd1, 32'h012, 32'h0, 32'h8765_4321, 0,
                32'hFFFF_8765, 4'b1100, 32'h0, 32'h010, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 32'h0000_F000, 1,
                32'h0000_00F0, 4'b0010, 32'h0, 32'h100, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 3'd3, 32'h020, 32'h0, 32'hCAFE_F00D, 0,
                32'hCAFE_F00D, 4'b1111, 32'h0, 32'h020, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 3'd4, 32'h030, 32'h1122_3344, 32'h0, 0,
                32'hCAFE_F00D, 4'b1111, 32'h1122_3344, 32'h030, 1'b0};

    reset = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    func3_in = 3'd0;
    address_in = 32'h0;
    write_data_in = 32'h0;
    mem_readdata = 32'h0;
    mem_busywait = 1'b0;
    fmt_rdata = 32'h0;
    fmt_addr = 2'd0;
    fmt_f3 = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.mem_read", 32'(mem_read), 32'(0));
    checkOutput("rst.mem_write", 32'(mem_write), 32'(0));
    checkOutput("rst.mem_address", mem_address, 32'h0);
    checkOutput("rst.mem_writedata", mem_writedata, 32'h0);
    checkOutput("rst.mem_byteenable", 32'(mem_byteenable), 32'h0);
    checkOutput("rst.result", d_mem_result_out, 32'h0);
    checkOutput("rst.misalign", 32'(misalign_out), 32'(0));
    checkOutput("rst.stall_idle", 32'(stall_out), 32'(0));
    mem_read_in = 1'b1;
    #1;
    checkOutput("rst.stall_follows_op", 32'(stall_out), 32'(1));
    mem_read_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                    vecs[i].word, vecs[i].waits, $sformatf("vec%0d", i), o);
      e = '{default: 0};
      e.stalls = vecs[i].waits + 2;
      e.reqs   = vecs[i].waits + 1;
      e.result = vecs[i].exp_result;
      e.addr   = vecs[i].exp_addr;
      e.be     = vecs[i].exp_be;
      e.wdata  = vecs[i].exp_wdata;
      e.rd     = vecs[i].exp_rd;
      e.wr     = !vecs[i].exp_rd;
      compareObs($sformatf("vec%0d", i), o, e, 1'b1);
      last_result = vecs[i].exp_result;
    end

    // Reset while a request is outstanding, then a normal load after release.
    mem_read_in = 1'b1;
    func3_in = 3'd2;
    address_in = 32'h40;
    mem_busywait = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstbusy.req_before", 32'(mem_read), 32'(1));
    reset = 1'b0;
    mem_read_in = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstbusy.mem_read", 32'(mem_read), 32'(0));
    checkOutput("rstbusy.stall", 32'(stall_out), 32'(0));
    checkOutput("rstbusy.result", d_mem_result_out, 32'h0);
    checkOutput("rstbusy.address", mem_address, 32'h0);
    checkOutput("rstbusy.byteenable", 32'(mem_byteenable), 32'h0);
    reset = 1'b1;
    mem_busywait = 1'b0;
    last_result = 32'h0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h44, 32'h0, 32'h0BAD_F00D, 1, "after_rst", o);
    e = '{default: 0};
    e.stalls = 3;
    e.reqs = 2;
    e.result = 32'h0BAD_F00D;
    e.addr = 32'h44;
    e.be = 4'b1111;
    e.rd = 1'b1;
    compareObs("after_rst", o, e, 1'b0);
    last_result = 32'h0BAD_F00D;

    // Misaligned word load.
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h006, 32'h0, 32'h55AA_55AA, 0, "lw_mis", o);
    e = '{default: 0};
`ifdef MISALIGN_TRAP_EN
    e.stalls = 1;
    e.reqs = 0;
    e.mis = 1;
    e.result = last_result;
`else
    e.stalls = 2;
    e.reqs = 1;
    e.mis = 0;
    e.result = 32'h55AA_55AA;
    e.addr = 32'h004;
    e.be = 4'b1111;
    e.rd = 1'b1;
`endif
    compareObs("lw_mis", o, e, 1'b0);
    checkOutput("lw_mis.misalign_after", 32'(misalign_out), 32'(0));
    last_result = e.result;

    for (int i = 0; i < 300; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, word;
      int          waits, size, lane;
      bit          mis;
      rd    = 1'($urandom_range(0, 1));
      wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wd    = $urandom;
      word  = $urandom;
      waits = $urandom_range(0, 3);
      size  = model_size(rd, f3);
      lane  = model_lane(addr, size);
      mis   = TRAP && ((int'(addr[1:0]) % size) != 0);
      applyStimulus(rd, wr, f3, addr, wd, word, waits, $sformatf("rnd%0d", i), o);
      if (!mis && rd) last_result = model_load(word, lane, size, f3);
      e = '{default: 0};
      e.stalls = mis ? 1 : waits + 2;
      e.reqs   = mis ? 0 : waits + 1;
      e.mis    = mis ? 1 : 0;
      e.result = last_result;
      e.addr   = addr & 32'hFFFF_FFFC;
      e.be     = model_be(lane, size);
      e.wdata  = model_wdata(wd, size);
      e.rd     = rd;
      e.wr     = !rd;
      compareObs($sformatf("rnd%0d", i), o, e, !rd);
    end

    for (int i = 0; i < 60; i++) begin
      int size;
      fmt_rdata = $urandom;
      fmt_addr  = 2'($urandom_range(0, 3));
      fmt_f3    = 3'($urandom_range(0, 7));
      #1;
      size = model_size(1'b1, fmt_f3);
      checkOutput($sformatf("fmt%0d", i), fmt_result,
                  model_load(fmt_rdata, model_lane({30'b0, fmt_addr}, size), size, fmt_f3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the RISC-V pipeline, sitting between the EX/MEM register and the MEM/WB register. Turns a load/store into a handshaked data-memory request and stalls the pipeline until memory acknowledges. Formats load data (lane select, sign/zero extension) into the 32-bit result that the MEM/WB register captures as the data-memory result.

## Interface
- Parameters: none; widths fixed at 32-bit data/address, 4 byte lanes.
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-low (0 = reset, sampled on posedge).
- `mem_read_in` in 1: load in this stage.
- `mem_write_in` in 1: store in this stage.
- `func3_in` in 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `address_in` in 32: ALU result (byte address).
- `write_data_in` in 32: store data (rs2 value).
- `mem_readdata` in 32: word read from data memory.
- `mem_busywait` in 1: memory busy; low while a request is asserted = acknowledge.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_address` out 32: word address (`address[31:2]`, low bits 00).
- `mem_writedata` out 32: store data replicated across lanes.
- `mem_byteenable` out 4: active byte lanes.
- `d_mem_result_out` out 32: formatted load result.
- `stall_out` out 1: freeze upstream pipeline registers.
- `misalign_out` out 1: misaligned-access flag.

## Operation
- FSM states IDLE, BUSY, DONE.
- IDLE: if `mem_read_in|mem_write_in`:
  - latch address, func3, write data, byte enables and op type into request registers;
  - go to BUSY, or to DONE for a trapped misalign.
  - Otherwise stay in IDLE.
- BUSY: `mem_read`/`mem_write` driven from the latched op.
  - On posedge with `mem_busywait`=0: capture the formatted load into `d_mem_result_out` (loads only), drop the request, go to DONE.
  - Otherwise stay in BUSY.
- DONE: no request; always go to IDLE. The pipeline advances at the end of this cycle, so the same instruction is never re-issued.
- `stall_out` (combinational) = (IDLE and op present) or BUSY.
- Byte enables:
  - SB: `0001<<addr[1:0]`.
  - SH: `0011<<{addr[1],1'b0}`.
  - SW: `1111`.
- Write data: SB replicates the byte 4x; SH replicates the halfword 2x; SW passes through.
- Load format: select the lane by `addr[1:0]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Read and write both asserted: treated as a load; the write is ignored.
- Undefined func3 on a load: acts as LW. On a store (011, 1xx): acts as SW.
- `d_mem_result_out` holds its value across stores and idle cycles until the next load completes.

## Timing
- Reset (reset=0 at posedge), including mid-BUSY:
  - state → IDLE;
  - `mem_read`/`mem_write` = 0 the next cycle;
  - `mem_address`, `mem_writedata`, `mem_byteenable`, `d_mem_result_out` = 0;
  - `misalign_out` = 0.
  - `stall_out` then follows the inputs combinationally.
- Request outputs are registered: asserted from the cycle after IDLE detects the op.
- Minimum latency with a zero-wait memory: IDLE (stall=1), BUSY (ack sampled), DONE (stall=0) = 2 stall cycles. Each extra busywait cycle adds one.
- `mem_busywait` is ignored outside BUSY.
- Request outputs are stable for the whole of BUSY.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Detects LH/LHU/SH with `addr[0]`=1 and LW/SW with `addr[1:0]`≠0.
  - No memory request is issued; IDLE goes straight to DONE (1 stall cycle).
  - `misalign_out`=1 for exactly the DONE cycle; `d_mem_result_out` is unchanged.
- Undefined:
  - `misalign_out` is tied 0.
  - Address low bits are forced to natural alignment: H clears bit 0, W clears bits 1:0.

## Structure
- Package `mem_access_pkg` holds:
  - funct3 constants (F3_B/H/W/BU/HU);
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - lane-mask constants.
- One combinational sub-module, `load_formatter`: (readdata, addr[1:0], func3) → 32-bit result. It is shared by the capture path and unit-tested alone.

## Test plan
- LB at addr 0x103, mem word 0x80FF_1234, zero wait:
  - BUSY has `mem_read`=1, `mem_address`=0x100;
  - DONE has `d_mem_result_out`=0xFFFF_FF80;
  - stall_out high exactly 2 cycles.
- SH at addr 0x202, data 0x0000_ABCD, busywait high 3 cycles:
  - `mem_byteenable`=1100, `mem_writedata`=0xABCD_ABCD held 4 cycles;
  - stall 5 cycles.
- LHU at 0x002, word 0x8001_0000: result 0x0000_8001. Then LW at 0x004, word 0xDEAD_BEEF: result 0xDEAD_BEEF. No re-issue of the first load.
- Reset (0) asserted during BUSY:
  - next cycle `mem_read`=0, state IDLE, `d_mem_result_out`=0;
  - a load presented after release completes normally.
- LW at 0x006:
  - with `MISALIGN_TRAP_EN`: no mem request, `misalign_out`=1 for one cycle, 1 stall cycle;
  - without: `mem_address`=0x004, `misalign_out`=0.
- Read and write both asserted at 0x010 with SW func3: acts as LW (`mem_read`=1, `mem_write`=0).
